xrisc_multicycle_ctrl: RTL and testbench

//  Control FSM that sequences a shared-memory multicycle X-RISC datapath (RV32I subset: lw, sw, R-type, I-type ALU, beq, jal).

---
 rtl/xrisc_multicycle_ctrl.sv | 176 +++++++++++++++++
 tb/tb_xrisc_multicycle_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/xrisc_multicycle_ctrl.sv
// rtl/xrisc_multicycle_ctrl.sv - multicycle X-RISC control FSM (RV32I subset, shared memory port)
// Sequences fetch/decode/execute phases; holds memory phases until mem_ready.
module xrisc_multicycle_ctrl #(
  parameter int USE_MEM_READY = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic [2:0] ALUControl,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       instr_done,
  output logic       illegal
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_JAL, S_BEQ, S_TRAP
  } state_t;

  typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} aluop_t;

  state_t state_q, state_d;
  aluop_t alu_op;
  logic   mem_ok;
  logic   ir_we, pc_we, reg_we, mem_we, done;

  assign mem_ok = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    alu_op    = ALUOP_ADD;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    AdrSrc    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    reg_we    = 1'b0;
    mem_we    = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_we     = mem_ok;
        pc_we     = mem_ok;
        if (mem_ok) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        unique case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ok) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_we    = 1'b1;
        done      = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        mem_we = 1'b1;
        done   = mem_ok;
        if (mem_ok) state_d = S_FETCH;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_we  = 1'b1;
        done    = 1'b1;
        state_d = S_FETCH;
      end
      // PC takes the target computed in DECODE while ALUOut captures PC+4 for rd.
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pc_we   = 1'b1;
        state_d = S_ALUWB;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_SUB;
        pc_we   = zero;
        done    = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ALUControl = 3'b000;
    unique case (alu_op)
      ALUOP_SUB: ALUControl = 3'b001;
      ALUOP_FUNCT: begin
        unique case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    ImmSrc = 2'b00;
    unique case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Gating with reset keeps enables low even in the FETCH state that reset forces.
  assign IRWrite    = ir_we  & ~reset;
  assign PCWrite    = pc_we  & ~reset;
  assign RegWrite   = reg_we & ~reset;
  assign MemWrite   = mem_we & ~reset;
  assign instr_done = done   & ~reset;
  assign illegal    = (state_q == S_TRAP) & ~reset;

endmodule

// File: tb/tb_xrisc_multicycle_ctrl.sv
// tb/tb_xrisc_multicycle_ctrl.sv - self-checking bench for xrisc_multicycle_ctrl
// Per-instruction totals are predicted from opcode rules, latencies and injected wait cycles.
`timescale 1ns/1ps
module tb_xrisc_multicycle_ctrl;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] BEQ = 7'b1100011;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, zero, mem_ready;
  logic [1:0] ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
  logic       AdrSrc;
  logic [2:0] ALUControl;
  logic       IRWrite, PCWrite, RegWrite, MemWrite, instr_done, illegal;

  int tests = 0;
  int fails = 0;

  xrisc_multicycle_ctrl #(.USE_MEM_READY(1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .mem_ready(mem_ready), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .AdrSrc(AdrSrc),
    .ALUControl(ALUControl), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .MemWrite(MemWrite), .instr_done(instr_done),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int base_cycles(input logic [6:0] o);
    if (o == LW) return 5;
    if (o == BEQ) return 3;
    return 4;
  endfunction

  // ALU operation expected on the third cycle of the instruction (EXEC / MEMADR / JAL / BEQ).
  function automatic int exp_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    if (o == BEQ) return 1;
    if (o != RT && o != IT) return 0;
    case (f3)
      3'd0:    return (o == RT && f7) ? 1 : 0;
      3'd2:    return 5;
      3'd6:    return 3;
      3'd7:    return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int exp_imm(input logic [6:0] o);
    if (o == SW) return 1;
    if (o == BEQ) return 2;
    if (o == JAL) return 3;
    return 0;
  endfunction

  // Entered just after a posedge with the DUT in FETCH; returns the same way.
  task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic z, input int fw, input int mw);
    bit is_mem;
    int total, ms, ir_n, pc_n, reg_n, mem_n, done_n, done_at, ill_n, adr_bad;
    int alu3, srca3, srcb0, rs_reg, imm_last;
    is_mem = (o == LW) || (o == SW);
    total  = base_cycles(o) + fw + (is_mem ? mw : 0);
    ms     = fw + 3;
    {ir_n, pc_n, reg_n, mem_n, done_n, ill_n, adr_bad} = '0;
    done_at = -1; rs_reg = -1; alu3 = -1; srca3 = -1; srcb0 = -1; imm_last = -1;
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    for (int c = 0; c < total; c++) begin
      mem_ready = !((c < fw) || (is_mem && c >= ms && c < ms + mw));
      @(negedge clk);
      if (IRWrite) ir_n++;
      if (PCWrite) pc_n++;
      if (RegWrite) begin reg_n++; rs_reg = ResultSrc; end
      if (MemWrite) begin mem_n++; if (AdrSrc !== 1'b1) adr_bad++; end
      if (instr_done) begin done_n++; done_at = c; end
      if (illegal) ill_n++;
      if (c == 0) srcb0 = ALUSrcB;
      if (c == fw + 2) begin alu3 = ALUControl; srca3 = ALUSrcA; end
      if (c == total - 1) imm_last = ImmSrc;
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    chk({tag, " done_count"}, done_n, 1);
    chk({tag, " done_cycle"}, done_at, total - 1);
    chk({tag, " irwrite"}, ir_n, 1);
    chk({tag, " pcwrite"}, pc_n, 1 + ((o == JAL) ? 1 : 0) + ((o == BEQ && z) ? 1 : 0));
    chk({tag, " regwrite"}, reg_n, (o == LW || o == RT || o == IT || o == JAL) ? 1 : 0);
    chk({tag, " memwrite"}, mem_n, (o == SW) ? 1 + mw : 0);
    chk({tag, " illegal"}, ill_n, 0);
    chk({tag, " alu_ctrl"}, alu3, exp_alu(o, f3, f7));
    chk({tag, " srca"}, srca3, (o == JAL) ? 1 : 2);
    chk({tag, " fetch_srcb"}, srcb0, 2);
    chk({tag, " immsrc"}, imm_last, exp_imm(o));
    if (reg_n > 0) chk({tag, " result_src"}, rs_reg, (o == LW) ? 1 : 0);
    if (mem_n > 0) chk({tag, " adrsrc"}, adr_bad, 0);
  endtask

  task automatic run_trap(input string tag, input logic [6:0] o);
    int en_n, ill_n;
    en_n = 0; ill_n = 0;
    op = o; mem_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        en_n += int'(IRWrite) + int'(PCWrite) + int'(RegWrite) + int'(MemWrite) + int'(instr_done);
        if (illegal) ill_n++;
      end
      @(posedge clk); #1;
    end
    chk({tag, " trap_enables"}, en_n, 0);
    chk({tag, " trap_illegal"}, ill_n, 5);
    reset = 1'b1;
    #1;
    chk({tag, " illegal_clear"}, illegal, 0);
    @(negedge clk);
    chk({tag, " reset_irwrite"}, IRWrite, 0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [6:0] ops [6];
    logic [2:0] f3s [5];
    logic [6:0] o;
    logic [2:0] f;
    ops = '{LW, SW, RT, IT, JAL, BEQ};
    f3s = '{3'd0, 3'd2, 3'd6, 3'd7, 3'd4};
    reset = 1'b1; mem_ready = 1'b1; op = RT; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_enables", int'(IRWrite) + int'(PCWrite) + int'(RegWrite) + int'(MemWrite) + int'(instr_done), 0);
    chk("reset_illegal", illegal, 0);
    @(posedge clk); #2;
    reset = 1'b0;

    run_instr("r_add", RT, 3'd0, 1'b0, 1'b0, 0, 0);
    run_instr("r_sub", RT, 3'd0, 1'b1, 1'b0, 0, 0);
    run_instr("r_slt", RT, 3'd2, 1'b0, 1'b0, 0, 0);
    run_instr("r_and", RT, 3'd7, 1'b0, 1'b0, 0, 0);
    run_instr("i_addf7", IT, 3'd0, 1'b1, 1'b0, 0, 0);
    run_instr("lw_wait2", LW, 3'd2, 1'b0, 1'b0, 0, 2);
    run_instr("sw_wait1", SW, 3'd2, 1'b0, 1'b0, 0, 1);
    run_instr("beq_taken", BEQ, 3'd0, 1'b0, 1'b1, 0, 0);
    run_instr("beq_not", BEQ, 3'd0, 1'b0, 1'b0, 0, 0);
    run_instr("jal", JAL, 3'd0, 1'b0, 1'b0, 0, 0);
    run_instr("fetch_wait", RT, 3'd6, 1'b0, 1'b0, 2, 0);

    run_trap("trap_ff", 7'b1111111);

    // Abort a store while it is still waiting for the memory.
    op = SW; funct3 = 3'd2; mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    @(negedge clk);
    chk("sw_before_reset", MemWrite, 1);
    #2 reset = 1'b1;
    #1;
    chk("sw_async_drop", MemWrite, 0);
    chk("sw_reset_done", instr_done, 0);
    @(posedge clk); #1;
    mem_ready = 1'b1;
    @(negedge clk);
    chk("sw_hold_reset", MemWrite, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_instr("after_abort", RT, 3'd0, 1'b1, 1'b0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      run_instr("rand", ops[$urandom_range(5)], f3s[$urandom_range(4)], 1'($urandom_range(1)),
                1'($urandom_range(1)), $urandom_range(2), $urandom_range(3));
    end

    for (int n = 0; n < 3; n++) begin
      do begin
        o = 7'($urandom_range(127));
      end while (o == LW || o == SW || o == RT || o == IT || o == JAL || o == BEQ);
      run_trap("rand_trap", o);
      f = f3s[$urandom_range(4)];
      run_instr("post_trap", IT, f, 1'b1, 1'b0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
